// File: rtl/alu_pkg.sv
// Shared op encodings and default widths for the integer ALU.
package alu_pkg;

  localparam int ALU_DATA_W  = 32;
  localparam int ALU_SHAMT_W = 5;
  localparam int ALU_OP_W    = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter (SLL/SRL/SRA), purely combinational, no flow control.
// Left shifts reverse the operand, reuse the right-shift stages, then reverse back.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic [DATA_W-1:0]  y
);

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

  logic              fill;
  logic [DATA_W-1:0] stage [SHAMT_W+1];

  // Sign fill only for arithmetic right shifts; a reversed left shift fills with zero.
  assign fill     = arith & ~left & a[DATA_W-1];
  assign stage[0] = left ? bit_rev(a) : a;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    assign stage[i+1] = shamt[i] ? {{SH{fill}}, stage[i][DATA_W-1:SH]} : stage[i];
  end

  assign y = left ? bit_rev(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: rtl/riscv_alu.sv
// RV32I integer ALU: combinational y/zero, plus y_q/out_valid one cycle later.
// No backpressure; a new operation may be accepted every cycle.
module riscv_alu
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = ALU_SHAMT_W,
  parameter int OP      = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP-1:0]     s,
  input  logic              ext,
  input  logic              in_valid,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic [DATA_W-1:0] y_q,
  output logic              out_valid
);

  logic              sub_en;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum_c;
  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              slt;
  logic              sltu;
  logic [DATA_W-1:0] shift_y;

  // Compares always subtract; carry out of a + ~b + 1 means a >= b unsigned.
  assign sub_en = ext | (s == ALU_SLT) | (s == ALU_SLTU);
  assign b_op   = sub_en ? ~b : b;
  assign sum_c  = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub_en};
  assign sum    = sum_c[DATA_W-1:0];
  assign carry  = sum_c[DATA_W];
  assign sltu   = ~carry;
  assign slt    = (a[DATA_W-1] != b[DATA_W-1]) ? a[DATA_W-1] : sum[DATA_W-1];

  alu_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .a     (a),
    .shamt (b[SHAMT_W-1:0]),
    .left  (s == ALU_SLL),
    .arith (ext),
    .y     (shift_y)
  );

  always_comb begin
    y = '0;
    case (s)
      ALU_ADD:  y = sum;
      ALU_SLL:  y = shift_y;
      ALU_SLT:  y = {{(DATA_W-1){1'b0}}, slt};
      ALU_SLTU: y = {{(DATA_W-1){1'b0}}, sltu};
      ALU_XOR:  y = a ^ b;
      ALU_SR:   y = shift_y;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y_q <= y;
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench with an expected-result queue drained by an output monitor.
module tb_riscv_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  s;
  logic        ext;
  logic        in_valid;
  logic [31:0] y, y_q;
  logic        zero, out_valid;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  s;
    logic        ext;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[$];
  logic [31:0] sb[$];

  riscv_alu dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .s         (s),
    .ext       (ext),
    .in_valid  (in_valid),
    .y         (y),
    .zero      (zero),
    .y_q       (y_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [31:0] va, input logic [31:0] vb,
                                  input logic [2:0] vs, input logic ve,
                                  input logic [31:0] vexp);
    vec_t v;
    v.a = va; v.b = vb; v.s = vs; v.ext = ve; v.exp = vexp;
    vt.push_back(v);
  endfunction

  // Monitor: every valid registered output must match the oldest expected result.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("y_q", y_q, e);
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    a = v.a; b = v.b; s = v.s; ext = v.ext; in_valid = 1'b1;
    #1;
    chk($sformatf("y[%0d]", idx), y, v.exp);
    chk($sformatf("zero[%0d]", idx), {31'd0, zero}, {31'd0, (v.exp == 32'd0)});
    sb.push_back(v.exp);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0;
    a = 32'd6; b = 32'd3; s = ALU_AND; ext = 1'b0;

    add_vec(32'd6,        32'd3,        ALU_AND,  1'b0, 32'd2);
    add_vec(32'd2,        32'd1,        ALU_OR,   1'b0, 32'd3);
    add_vec(32'd4,        32'd1,        ALU_XOR,  1'b0, 32'd5);
    add_vec(32'd1,        32'd3,        ALU_SLL,  1'b0, 32'd8);
    add_vec(32'd16,       32'd2,        ALU_SR,   1'b0, 32'd4);
    add_vec(32'h80000000, 32'd4,        ALU_SR,   1'b1, 32'hF8000000);
    add_vec(32'h80000000, 32'd4,        ALU_SR,   1'b0, 32'h08000000);
    add_vec(32'd1,        32'h23,       ALU_SLL,  1'b0, 32'd8);
    add_vec(32'h12345678, 32'd0,        ALU_SLL,  1'b0, 32'h12345678);
    add_vec(32'h12345678, 32'h20,       ALU_SR,   1'b1, 32'h12345678);
    add_vec(32'd1,        32'd31,       ALU_SLL,  1'b0, 32'h80000000);
    add_vec(32'h80000000, 32'd31,       ALU_SR,   1'b0, 32'd1);
    add_vec(32'h80000000, 32'd31,       ALU_SR,   1'b1, 32'hFFFFFFFF);
    add_vec(32'hFFFFFFFF, 32'd1,        ALU_ADD,  1'b0, 32'd0);
    add_vec(32'd5,        32'd7,        ALU_ADD,  1'b1, 32'hFFFFFFFE);
    add_vec(32'd5,        32'd7,        ALU_ADD,  1'b0, 32'd12);
    add_vec(32'd3,        32'd3,        ALU_ADD,  1'b1, 32'd0);
    add_vec(32'hFFFFFFFF, 32'd1,        ALU_SLT,  1'b0, 32'd1);
    add_vec(32'hFFFFFFFF, 32'd1,        ALU_SLTU, 1'b0, 32'd0);
    add_vec(32'd1,        32'hFFFFFFFF, ALU_SLTU, 1'b0, 32'd1);
    add_vec(32'd7,        32'd7,        ALU_SLT,  1'b0, 32'd0);
    add_vec(32'd7,        32'd7,        ALU_SLTU, 1'b0, 32'd0);
    add_vec(32'h80000000, 32'd0,        ALU_SLT,  1'b0, 32'd1);
    add_vec(32'd0,        32'h80000000, ALU_SLT,  1'b0, 32'd0);
    add_vec(32'h0000F0F0, 32'h0000FF00, ALU_AND,  1'b1, 32'h0000F000);
    add_vec(32'h0000F0F0, 32'h0000FF00, ALU_XOR,  1'b1, 32'h00000FF0);

    // Reset state, with the combinational path live during reset.
    #1;
    chk("y during reset", y, 32'd2);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset y_q", y_q, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);
    @(posedge clk);
    #1 in_valid = 1'b0;

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) chk("drain timeout", sb.size(), 32'd0);

    // Single pulse then an idle cycle: y_q must hold.
    v.a = 32'd2; v.b = 32'd3; v.s = ALU_ADD; v.ext = 1'b0; v.exp = 32'd5;
    apply(v, 100);
    @(posedge clk);
    #1 in_valid = 1'b0; a = 32'd9;
    @(posedge clk);
    @(negedge clk);
    chk("idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle y_q hold", y_q, 32'd5);

    // Reset wins over a simultaneous capture.
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; a = 32'd2; b = 32'd3; s = ALU_ADD; ext = 1'b0;
    #1 chk("y with rst", y, 32'd5);
    @(posedge clk);
    @(negedge clk);
    chk("rst+valid y_q", y_q, 32'd0);
    chk("rst+valid out_valid", {31'd0, out_valid}, 32'd0);
    a = 32'd10; b = 32'd4; ext = 1'b1;
    #1 chk("y sub in reset", y, 32'd6);
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("scoreboard empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
